// File: rtl/counter_button_ctrl_if.sv
// Board-side button pins and counter command outputs of the button controller.
// The slave modport is the controller; the master modport is the board/counter side.
interface counter_button_ctrl_if;
    logic       BtnUp_n;
    logic       BtnDown_n;
    logic       BtnSign_n;
    logic       Up;
    logic       Down;
    logic       SignSwitch;
    logic [1:0] Owner;

    modport master (
        output BtnUp_n,
        output BtnDown_n,
        output BtnSign_n,
        input  Up,
        input  Down,
        input  SignSwitch,
        input  Owner
    );

    modport slave (
        input  BtnUp_n,
        input  BtnDown_n,
        input  BtnSign_n,
        output Up,
        output Down,
        output SignSwitch,
        output Owner
    );
endinterface

// File: rtl/counter_button_ctrl.sv
// Synchronises, debounces and arbitrates three active-low push-buttons into single-cycle
// Up/Down/SignSwitch commands, with optional auto-repeat for Up/Down.
module counter_button_ctrl #(
    parameter int unsigned DebounceCycles = 50000,
    parameter int unsigned RepeatDelay    = 25000000,
    parameter int unsigned RepeatPeriod   = 5000000,
    parameter bit          AutoRepeat     = 1'b1
) (
    input logic                  Clock,
    input logic                  Reset,
    counter_button_ctrl_if.slave bus
);

    localparam int unsigned DbW    = $clog2(DebounceCycles);
    localparam int unsigned RptMax = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
    localparam int unsigned RptW   = $clog2(RptMax);

    localparam logic [DbW-1:0]  DbLast   = DbW'(DebounceCycles - 1);
    // The PULSE cycle and the reload cycle both count towards the first repeat delay.
    localparam logic [RptW-1:0] RptFirst = RptW'(RepeatDelay - 2);
    localparam logic [RptW-1:0] RptNext  = RptW'(RepeatPeriod - 1);

    localparam logic [1:0] OwnNone = 2'b00;
    localparam logic [1:0] OwnUp   = 2'b01;
    localparam logic [1:0] OwnDown = 2'b10;
    localparam logic [1:0] OwnSign = 2'b11;

    typedef enum logic [1:0] {StIdle, StPulse, StHold, StWaitRelease} state_e;

    // Button vectors are indexed 0 = Up, 1 = Down, 2 = Sign, in raw (active-low) polarity.
    logic [2:0]     raw;
    logic [2:0]     sync1_q, sync2_q, deb_q;
    logic [DbW-1:0] dbcnt_q [3];
    logic [2:0]     pressed;

    state_e          state_q;
    logic [1:0]      owner_q;
    logic            up_q, down_q, sign_q;
    logic [RptW-1:0] rpt_q;
    logic            owner_pressed;

    assign raw     = {bus.BtnSign_n, bus.BtnDown_n, bus.BtnUp_n};
    assign pressed = ~deb_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            deb_q   <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                dbcnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    dbcnt_q[i] <= '0;
                end else if (dbcnt_q[i] == DbLast) begin
                    deb_q[i]   <= sync2_q[i];
                    dbcnt_q[i] <= '0;
                end else begin
                    dbcnt_q[i] <= dbcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        owner_pressed = 1'b0;
        if (owner_q == OwnUp) begin
            owner_pressed = pressed[0];
        end else if (owner_q == OwnDown) begin
            owner_pressed = pressed[1];
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= StIdle;
            owner_q <= OwnNone;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            sign_q  <= 1'b0;
            rpt_q   <= '0;
        end else begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            sign_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pressed[2]) begin
                        owner_q <= OwnSign;
                        sign_q  <= 1'b1;
                        state_q <= StPulse;
                    end else if (pressed[0]) begin
                        owner_q <= OwnUp;
                        up_q    <= 1'b1;
                        state_q <= StPulse;
                    end else if (pressed[1]) begin
                        owner_q <= OwnDown;
                        down_q  <= 1'b1;
                        state_q <= StPulse;
                    end
                end
                StPulse: begin
                    if (owner_q == OwnSign || !AutoRepeat) begin
                        state_q <= StWaitRelease;
                    end else begin
                        state_q <= StHold;
                        rpt_q   <= RptFirst;
                    end
                end
                StHold: begin
                    // A release seen on the same edge as a due repeat suppresses the repeat.
                    if (!owner_pressed) begin
                        state_q <= StWaitRelease;
                    end else if (rpt_q == '0) begin
                        up_q   <= (owner_q == OwnUp);
                        down_q <= (owner_q == OwnDown);
                        rpt_q  <= RptNext;
                    end else begin
                        rpt_q <= rpt_q - 1'b1;
                    end
                end
                StWaitRelease: begin
                    if (&deb_q) begin
                        state_q <= StIdle;
                        owner_q <= OwnNone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.Up         = up_q;
    assign bus.Down       = down_q;
    assign bus.SignSwitch = sign_q;
    assign bus.Owner      = owner_q;

endmodule

// File: tb/tb_counter_button_ctrl.sv
// Scoreboard bench for counter_button_ctrl: expected pulses (cycle, kind) are queued as
// buttons are driven and compared as the DUTs emit them.
module tb_counter_button_ctrl;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   cyc   = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    counter_button_ctrl_if bus ();
    counter_button_ctrl_if bus_nr ();

    counter_button_ctrl #(
        .DebounceCycles(4),
        .RepeatDelay   (10),
        .RepeatPeriod  (4),
        .AutoRepeat    (1'b1)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    counter_button_ctrl #(
        .DebounceCycles(4),
        .RepeatDelay   (10),
        .RepeatPeriod  (4),
        .AutoRepeat    (1'b0)
    ) dut_nr (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus_nr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Kinds: 1 Up, 2 Down, 3 Sign on dut; +4 for dut_nr.
    task automatic expect_pulse(input int c, input int kind);
        exp_q.push_back(c * 8 + kind);
    endtask

    function automatic int kind_of(input logic [2:0] v);
        if (v[2]) return 3;
        if (v[1]) return 2;
        return 1;
    endfunction

    task automatic take_pulse(input int kind);
        int e;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_pulse", kind, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq("pulse_cycle", cyc, e / 8);
            check_eq("pulse_kind", kind, e % 8);
        end
    endtask

    logic [2:0] mon_a, mon_b;
    always @(negedge Clock) begin
        mon_a = {bus.SignSwitch, bus.Down, bus.Up};
        mon_b = {bus_nr.SignSwitch, bus_nr.Down, bus_nr.Up};
        if ($countones(mon_a) > 1) check_eq("onehot", $countones(mon_a), 1);
        if ($countones(mon_b) > 1) check_eq("onehot_nr", $countones(mon_b), 1);
        if (mon_a != 3'b000) take_pulse(kind_of(mon_a));
        if (mon_b != 3'b000) take_pulse(4 + kind_of(mon_b));
    end

    // Advance to the falling edge of cycle c (cycle count is updated at each rising edge).
    task automatic go(input int c);
        while (cyc < c) @(negedge Clock);
    endtask

    int b;

    initial begin
        bus.BtnUp_n      = 1'b1;
        bus.BtnDown_n    = 1'b1;
        bus.BtnSign_n    = 1'b1;
        bus_nr.BtnUp_n   = 1'b1;
        bus_nr.BtnDown_n = 1'b1;
        bus_nr.BtnSign_n = 1'b1;

        go(2);
        check_eq("rst_owner", bus.Owner, 0);
        check_eq("rst_up", bus.Up, 0);
        check_eq("rst_down", bus.Down, 0);
        check_eq("rst_sign", bus.SignSwitch, 0);
        Reset = 1'b1;

        // Single Up press held 8 cycles
        go(5);
        b = cyc;
        bus.BtnUp_n = 1'b0;
        expect_pulse(b + 7, 1);
        go(b + 6);
        check_eq("s1_owner_pre", bus.Owner, 0);
        go(b + 7);
        check_eq("s1_owner", bus.Owner, 1);
        go(b + 8);
        bus.BtnUp_n = 1'b1;
        go(b + 30);
        check_eq("s1_owner_idle", bus.Owner, 0);
        check_eq("s1_sb_empty", exp_q.size(), 0);

        // Down held 40 cycles: auto-repeat
        b = cyc;
        bus.BtnDown_n = 1'b0;
        expect_pulse(b + 7, 2);
        for (int t = 17; t <= 46; t += 4) expect_pulse(b + t, 2);
        go(b + 7);
        check_eq("s2_owner", bus.Owner, 2);
        go(b + 40);
        bus.BtnDown_n = 1'b1;
        go(b + 60);
        check_eq("s2_owner_idle", bus.Owner, 0);
        check_eq("s2_sb_empty", exp_q.size(), 0);

        // Sign held 40 cycles: one pulse only
        b = cyc;
        bus.BtnSign_n = 1'b0;
        expect_pulse(b + 7, 3);
        go(b + 7);
        check_eq("s3_owner", bus.Owner, 3);
        go(b + 40);
        bus.BtnSign_n = 1'b1;
        go(b + 45);
        check_eq("s3_owner_held", bus.Owner, 3);
        go(b + 60);
        check_eq("s3_owner_idle", bus.Owner, 0);
        check_eq("s3_sb_empty", exp_q.size(), 0);

        // AutoRepeat=0: Up held 40 cycles
        b = cyc;
        bus_nr.BtnUp_n = 1'b0;
        expect_pulse(b + 7, 5);
        go(b + 7);
        check_eq("s4_owner", bus_nr.Owner, 1);
        go(b + 40);
        bus_nr.BtnUp_n = 1'b1;
        go(b + 60);
        check_eq("s4_owner_idle", bus_nr.Owner, 0);
        check_eq("s4_sb_empty", exp_q.size(), 0);

        // Up and Sign together: Sign wins, Up locked out until re-pressed
        b = cyc;
        bus.BtnUp_n   = 1'b0;
        bus.BtnSign_n = 1'b0;
        expect_pulse(b + 7, 3);
        go(b + 7);
        check_eq("s5_owner", bus.Owner, 3);
        go(b + 20);
        bus.BtnSign_n = 1'b1;
        go(b + 35);
        check_eq("s5_owner_locked", bus.Owner, 3);
        go(b + 40);
        bus.BtnUp_n = 1'b1;
        go(b + 60);
        check_eq("s5_owner_idle", bus.Owner, 0);
        b = cyc;
        bus.BtnUp_n = 1'b0;
        expect_pulse(b + 7, 1);
        go(b + 9);
        bus.BtnUp_n = 1'b1;
        go(b + 30);
        check_eq("s5_sb_empty", exp_q.size(), 0);

        // Short glitches on Up never reach the debounced level
        b = cyc;
        for (int i = 0; i < 6; i++) begin
            go(b + 5 * i);
            bus.BtnUp_n = 1'b0;
            go(b + 5 * i + 3);
            bus.BtnUp_n = 1'b1;
        end
        go(b + 50);
        check_eq("s6_owner", bus.Owner, 0);
        check_eq("s6_sb_empty", exp_q.size(), 0);

        // Reset during HOLD, button still held afterwards
        b = cyc;
        bus.BtnDown_n = 1'b0;
        expect_pulse(b + 7, 2);
        go(b + 12);
        check_eq("s7_owner_hold", bus.Owner, 2);
        Reset = 1'b0;
        go(b + 13);
        check_eq("s7_rst_owner", bus.Owner, 0);
        check_eq("s7_rst_down", bus.Down, 0);
        check_eq("s7_rst_up", bus.Up, 0);
        check_eq("s7_rst_sign", bus.SignSwitch, 0);
        Reset = 1'b1;
        expect_pulse(b + 20, 2);
        go(b + 19);
        check_eq("s7_owner_pre", bus.Owner, 0);
        go(b + 20);
        check_eq("s7_owner", bus.Owner, 2);
        go(b + 22);
        bus.BtnDown_n = 1'b1;
        go(b + 45);
        check_eq("s7_owner_idle", bus.Owner, 0);
        check_eq("s7_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
